// File: rtl/bist_pkg.sv
// bist_pkg: constants and types shared by the BIST pattern generator, MISR and controller.
package bist_pkg;

    localparam logic [15:0] LFSR_POLY_TAPS    = 16'hB400;
    localparam logic [15:0] DEFAULT_SEED      = 16'hACE1;
    localparam int          DEFAULT_NUM_PAIRS = 32;

    typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} tpg_state_e;

endpackage

// File: rtl/lfsr_tpg_if.sv
// lfsr_tpg_if: operand-pair valid/ready channel from the pattern generator to the multiplier.
interface lfsr_tpg_if #(
    parameter int WIDTH = 8
);

    logic [WIDTH-1:0] operand_a;
    logic [WIDTH-1:0] operand_b;
    logic             pattern_valid;
    logic             consumer_ready;
    logic [5:0]       pair_index;

    modport master (
        output operand_a, operand_b, pattern_valid, pair_index,
        input  consumer_ready
    );

    modport slave (
        input  operand_a, operand_b, pattern_valid, pair_index,
        output consumer_ready
    );

endinterface

// File: rtl/lfsr16_step.sv
// lfsr16_step: one Fibonacci left-shift step of x^16+x^14+x^13+x^11+1.
module lfsr16_step
    import bist_pkg::*;
(
    input  logic [15:0] lfsr_i,
    output logic [15:0] lfsr_o
);

    assign lfsr_o = {lfsr_i[14:0], ^(lfsr_i & LFSR_POLY_TAPS)};

endmodule

// File: rtl/lfsr_tpg.sv
// lfsr_tpg: LFSR operand-pair generator for multiplier BIST, with a MISR run line
// delayed to line up with the multiplier's first result.
module lfsr_tpg
    import bist_pkg::*;
#(
    parameter int          WIDTH     = 8,
    parameter int          NUM_PAIRS = DEFAULT_NUM_PAIRS,
    parameter logic [15:0] SEED      = DEFAULT_SEED,
    parameter int          PIPE_LAT  = 0
) (
    input  logic       clk,
    input  logic       reset_to_tpg,
    input  logic       start,
    lfsr_tpg_if.master tpg,
    output logic       misr_run,
    output logic       done
);

    // An all-zero seed would lock the LFSR up.
    localparam logic [15:0] SEED_EFF = (SEED == 16'h0000) ? 16'h0001 : SEED;
    localparam logic [6:0]  LAST     = 7'(NUM_PAIRS - 1);

    tpg_state_e  state_q;
    logic [15:0] lfsr_q;
    logic [15:0] lfsr_d;
    logic [6:0]  count_q;
    logic        valid_q;
    logic        done_q;
    logic        xfer;
    logic        run_flag;

    lfsr16_step u_step (
        .lfsr_i (lfsr_q),
        .lfsr_o (lfsr_d)
    );

    assign xfer     = valid_q & tpg.consumer_ready;
    assign run_flag = (state_q == RUN) | (state_q == DONE);

    always_ff @(posedge clk or negedge reset_to_tpg) begin
        if (!reset_to_tpg) begin
            state_q <= IDLE;
            lfsr_q  <= SEED_EFF;
            count_q <= '0;
            valid_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: if (start) state_q <= LOAD;
                LOAD: begin
                    lfsr_q  <= SEED_EFF;
                    count_q <= '0;
                    valid_q <= 1'b1;
                    state_q <= RUN;
                end
                RUN: if (xfer) begin
                    lfsr_q  <= lfsr_d;
                    count_q <= count_q + 7'd1;
                    if (count_q == LAST) begin
                        valid_q <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= DONE;
                    end
                end
                DONE: if (start) begin
                    done_q  <= 1'b0;
                    state_q <= LOAD;
                end
            endcase
        end
    end

    // The LOAD cycle's zero run_flag travels down the chain, so every restart reaches the MISR.
    generate
        if (PIPE_LAT == 0) begin : g_nodly
            assign misr_run = run_flag;
        end else begin : g_dly
            logic [PIPE_LAT-1:0] dly_q;
            always_ff @(posedge clk or negedge reset_to_tpg) begin
                if (!reset_to_tpg) dly_q <= '0;
                else dly_q <= PIPE_LAT'({dly_q, run_flag});
            end
            assign misr_run = dly_q[PIPE_LAT-1];
        end
    endgenerate

    assign tpg.operand_a     = lfsr_q[2*WIDTH-1:WIDTH];
    assign tpg.operand_b     = lfsr_q[WIDTH-1:0];
    assign tpg.pattern_valid = valid_q;
    assign tpg.pair_index    = count_q[5:0];
    assign done              = done_q;

endmodule

// File: tb/tb_lfsr_tpg.sv
// tb_lfsr_tpg: directed and randomized checks of lfsr_tpg (PIPE_LAT 0 and 2) against a cycle reference model.
module tb_lfsr_tpg;

    localparam int NP = 32;

    logic clk = 1'b0;
    logic rst_n;
    logic start;
    logic ready;
    logic misr0, misr2, done0, done2;

    lfsr_tpg_if #(.WIDTH(8)) bus0 ();
    lfsr_tpg_if #(.WIDTH(8)) bus2 ();

    assign bus0.consumer_ready = ready;
    assign bus2.consumer_ready = ready;

    lfsr_tpg u0 (
        .clk          (clk),
        .reset_to_tpg (rst_n),
        .start        (start),
        .tpg          (bus0),
        .misr_run     (misr0),
        .done         (done0)
    );

    lfsr_tpg #(.PIPE_LAT(2)) u2 (
        .clk          (clk),
        .reset_to_tpg (rst_n),
        .start        (start),
        .tpg          (bus2),
        .misr_run     (misr2),
        .done         (done2)
    );

    always #5 clk = ~clk;

    // Reference: expected pattern table plus a phase/index tracker and run-flag history.
    logic [15:0] pat [0:64];
    int ph;    // 0 idle, 1 load, 2 run, 3 done
    int idx;
    bit r1, r2;
    int tests = 0;
    int fails = 0;
    int xfers = 0;
    logic [7:0] hold_a, hold_b;

    function automatic logic [15:0] lfsr_next(logic [15:0] l);
        return {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
    endfunction

    task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset;
        ph = 0;
        idx = 0;
        r1 = 1'b0;
        r2 = 1'b0;
    endtask

    task automatic model_edge;
        bit run_now;
        run_now = (ph >= 2);
        r2 = r1;
        r1 = run_now;
        case (ph)
            0: if (start) ph = 1;
            1: begin ph = 2; idx = 0; end
            2: if (ready) begin
                if (idx == NP - 1) ph = 3;
                else idx++;
            end
            default: if (start) ph = 1;
        endcase
    endtask

    task automatic check_all;
        check("valid", bus0.pattern_valid, ph == 2);
        check("valid_lat2", bus2.pattern_valid, ph == 2);
        check("done", done0, ph == 3);
        check("done_lat2", done2, ph == 3);
        check("misr_run", misr0, ph >= 2);
        check("misr_run_lat2", misr2, r2);
        if (ph == 2) begin
            check("pair_index", bus0.pair_index, idx);
            check("operand_a", bus0.operand_a, pat[idx][15:8]);
            check("operand_b", bus0.operand_b, pat[idx][7:0]);
            check("operand_a_lat2", bus2.operand_a, pat[idx][15:8]);
        end
    endtask

    task automatic step(bit s, bit r);
        start = s;
        ready = r;
        xfers += int'(bus0.pattern_valid && ready);
        @(posedge clk);
        model_edge();
        #1;
        check_all();
    endtask

    task automatic do_reset;
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        start = 1'b0;
        #1;
        model_reset();
        check_all();
        check("rst_pair_index", bus0.pair_index, 0);
        check("rst_operand_a", bus0.operand_a, 8'hAC);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        pat[0] = 16'hACE1;
        for (int i = 1; i <= 64; i++) pat[i] = lfsr_next(pat[i-1]);
        rst_n = 1'b0;
        start = 1'b0;
        ready = 1'b1;
        model_reset();
        #3;
        check_all();
        check("rst_pair_index", bus0.pair_index, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // First patterns after start
        step(0, 1);
        step(1, 1);
        check("load_no_valid", bus0.pattern_valid, 0);
        xfers = 0;
        step(0, 1);
        check("p0_a", bus0.operand_a, 8'hAC);
        check("p0_b", bus0.operand_b, 8'hE1);
        check("p0_idx", bus0.pair_index, 0);
        step(0, 1);
        check("p1_a", bus0.operand_a, 8'h59);
        check("p1_b", bus0.operand_b, 8'hC3);
        check("p1_idx", bus0.pair_index, 1);
        step(0, 1);
        check("p2_a", bus0.operand_a, 8'hB3);
        check("p2_b", bus0.operand_b, 8'h87);
        check("p2_idx", bus0.pair_index, 2);

        // Stall at index 5
        while (idx < 5) step(0, 1);
        hold_a = bus0.operand_a;
        hold_b = bus0.operand_b;
        repeat (3) step(0, 0);
        check("stall_a", bus0.operand_a, hold_a);
        check("stall_b", bus0.operand_b, hold_b);
        check("stall_idx", bus0.pair_index, 5);
        step(0, 1);
        check("resume_a", bus0.operand_a, pat[6][15:8]);

        // start mid-run is ignored
        while (idx < 10) step(0, 1);
        step(1, 1);
        check("start_in_run_valid", bus0.pattern_valid, 1);
        check("start_in_run_idx", bus0.pair_index, 11);
        for (int g = 0; g < 100 && ph == 2; g++) step(0, 1);
        check("xfer_count", xfers, NP);
        check("done_after_run", done0, 1);
        check("no_valid_in_done", bus0.pattern_valid, 0);

        // Restart from DONE
        step(0, 1);
        step(1, 1);
        check("restart_load_misr", misr0, 0);
        check("restart_load_valid", bus0.pattern_valid, 0);
        step(0, 1);
        check("restart_a", bus0.operand_a, 8'hAC);
        check("restart_b", bus0.operand_b, 8'hE1);

        // Asynchronous reset at index 17, then restart from SEED
        while (idx < 17) step(0, 1);
        do_reset();
        step(1, 1);
        step(0, 1);
        check("post_rst_a", bus0.operand_a, 8'hAC);
        check("post_rst_b", bus0.operand_b, 8'hE1);
        check("post_rst_idx", bus0.pair_index, 0);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 399) == 0) do_reset();
            step($urandom_range(0, 15) == 0, $urandom_range(0, 3) != 0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
